// File: rtl/imem_prog_loader.sv
// Instruction memory program loader: assembles a big-endian byte stream (word-count header,
// then instruction words) into imem writes and holds the CPU in reset until the image is in.
module imem_prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  byte_in_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_data_o,
  output logic        cpu_rst_o,
  output logic        cpu_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_loaded_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StData, StWrite, StDone, StErr} state_e;

  state_e state_q, state_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     shift_q, shift_d;
  logic [15:0]     n_q, n_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [15:0]     words_q, words_d;
  logic            ready_q, we_q, busy_q, done_q, err_q, cpu_rst_q, cpu_en_q;

  logic        accept;
  logic [15:0] hdr_n;

  // ready_q mirrors "state is HDR or DATA", so it doubles as the handshake qualifier
  assign accept = byte_valid_i && ready_q;
  // Only the low 16 bits of the header count are kept
  assign hdr_n  = {shift_q[7:0], byte_in_i};

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    n_d     = n_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        tmo_d = '0;
        if (start_i) begin
          state_d = StHdr;
          bcnt_d  = '0;
          words_d = '0;
        end
      end
      StHdr: begin
        if (accept) begin
          tmo_d   = '0;
          shift_d = {shift_q[15:0], byte_in_i};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            n_d = hdr_n;
            if (hdr_n == 16'd0) begin
              state_d = StDone;
            end else if (32'(hdr_n) > MAX_WORDS) begin
              state_d = StErr;
            end else begin
              state_d = StData;
            end
          end
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StData: begin
        if (accept) begin
          tmo_d   = '0;
          shift_d = {shift_q[15:0], byte_in_i};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            data_d  = {shift_q, byte_in_i};
            addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
            state_d = StWrite;
          end
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWrite: begin
        tmo_d   = '0;
        words_d = words_q + 16'd1;
        if ((words_q + 16'd1) < n_q) begin
          state_d = StData;
        end else begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      bcnt_q    <= '0;
      shift_q   <= '0;
      n_q       <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      words_q   <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
      cpu_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      n_q       <= n_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      words_q   <= words_d;
      // Status outputs are decoded from the next state so they are registered yet in step
      ready_q   <= (state_d == StHdr) || (state_d == StData);
      we_q      <= (state_d == StWrite);
      busy_q    <= (state_d == StHdr) || (state_d == StData) || (state_d == StWrite);
      done_q    <= (state_d == StDone);
      err_q     <= (state_d == StErr);
      cpu_rst_q <= (state_d != StDone);
      cpu_en_q  <= (state_d == StDone);
    end
  end

  assign byte_ready_o   = ready_q;
  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_data_o    = data_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign cpu_en_o       = cpu_en_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = err_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader: directed scenarios plus random images, writes checked by a
// scoreboard queue filled from a byte-stream reference model.
module tb_imem_prog_loader;

  localparam logic [31:0] Base = 32'h0000_0000;
  localparam int unsigned MaxW = 4;
  localparam int unsigned Tmo  = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  byte_in_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o, imem_we_o, cpu_rst_o, cpu_en_o, busy_o, done_o, error_o;
  logic [31:0] imem_addr_o, imem_data_o;
  logic [15:0] words_loaded_o;

  imem_prog_loader #(
    .BASE_ADDR(Base),
    .MAX_WORDS(MaxW),
    .TIMEOUT  (Tmo)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .byte_in_i     (byte_in_i),
    .byte_valid_i  (byte_valid_i),
    .byte_ready_o  (byte_ready_o),
    .imem_we_o     (imem_we_o),
    .imem_addr_o   (imem_addr_o),
    .imem_data_o   (imem_data_o),
    .cpu_rst_o     (cpu_rst_o),
    .cpu_en_o      (cpu_en_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .words_loaded_o(words_loaded_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected-write queue
  initial begin
    bit  prev_we;
    wr_t w;
    prev_we = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && imem_we_o) begin
        chk("ready_low_in_write", {31'd0, byte_ready_o}, 32'd0);
        chk("we_single_pulse", {31'd0, prev_we}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                   imem_addr_o, imem_data_o);
        end else begin
          w = exp_q.pop_front();
          chk("write_addr", imem_addr_o, w.addr);
          chk("write_data", imem_data_o, w.data);
        end
      end
      prev_we = rst_ni && imem_we_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs();
    chk("rst_byte_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we_o}, 32'd0);
    chk("rst_imem_addr", imem_addr_o, 32'd0);
    chk("rst_imem_data", imem_data_o, 32'd0);
    chk("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    chk("rst_cpu_en", {31'd0, cpu_en_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_error", {31'd0, error_o}, 32'd0);
    chk("rst_words", {16'd0, words_loaded_o}, 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Holds the byte valid until the loader takes it; returns 1ns after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_in_i    = b;
    byte_valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (byte_ready_o) begin
        @(posedge clk_i);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL byte_accept: byte 0x%02h not accepted within 40 cycles, expected accept", b);
    end
  endtask

  // Reference model over the whole image, then drive it and check the final status
  task automatic run_load(input int gap_max, input bit noise);
    int  n, avail, words, g;
    bit  full_hdr, exp_done, seen;
    wr_t w;
    n = 0;
    words = 0;
    full_hdr = (stim.size() >= 4);
    if (!full_hdr) begin
      exp_done = 1'b0;
    end else begin
      n = int'({stim[2], stim[3]});
      if (n == 0) begin
        exp_done = 1'b1;
      end else if (n > int'(MaxW)) begin
        exp_done = 1'b0;
      end else begin
        avail = (stim.size() - 4) / 4;
        exp_done = (avail >= n);
        words = exp_done ? n : avail;
        for (int k = 0; k < words; k++) begin
          w.addr = Base + 32'(4 * k);
          w.data = {stim[4+4*k], stim[5+4*k], stim[6+4*k], stim[7+4*k]};
          exp_q.push_back(w);
        end
      end
    end
    do_start();
    chk("start_busy", {31'd0, busy_o}, 32'd1);
    chk("start_done_clear", {31'd0, done_o}, 32'd0);
    chk("start_error_clear", {31'd0, error_o}, 32'd0);
    chk("start_words_clear", {16'd0, words_loaded_o}, 32'd0);
    chk("start_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    for (int i = 0; i < stim.size(); i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) byte_valid_i = 1'b0;
      for (int j = 0; j < g; j++) begin
        if (noise && ($urandom_range(3, 0) == 0)) start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
      end
      send_byte(stim[i]);
    end
    byte_valid_i = 1'b0;
    if (full_hdr && (n == 0 || n > int'(MaxW))) begin
      chk("hdr_done_now", {31'd0, done_o}, {31'd0, (n == 0)});
      chk("hdr_error_now", {31'd0, error_o}, {31'd0, (n != 0)});
    end
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done_o || error_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    chk("load_ended", {31'd0, seen}, 32'd1);
    chk("end_done", {31'd0, done_o}, {31'd0, exp_done});
    chk("end_error", {31'd0, error_o}, {31'd0, !exp_done});
    chk("end_cpu_en", {31'd0, cpu_en_o}, {31'd0, exp_done});
    chk("end_cpu_rst", {31'd0, cpu_rst_o}, {31'd0, !exp_done});
    chk("end_busy", {31'd0, busy_o}, 32'd0);
    chk("end_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("end_words", {16'd0, words_loaded_o}, 32'(words));
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          n, full, len;
    logic [15:0] nh;
    wr_t         w;

    repeat (3) @(negedge clk_i);
    check_reset_outputs();
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Normal two-word load
    stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    run_load(2, 1'b0);

    // Zero count
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load(0, 1'b0);

    // Backpressure: valid held high through both WRITE cycles
    stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03,
             8'h04, 8'h05, 8'h06, 8'h07};
    run_load(0, 1'b0);
    byte_in_i    = 8'h08;
    byte_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("no_accept_after_done", {31'd0, byte_ready_o}, 32'd0);
    end
    byte_valid_i = 1'b0;
    chk("done_held", {31'd0, done_o}, 32'd1);

    // Oversize header
    stim = '{8'h00, 8'h00, 8'h00, 8'h05};
    run_load(0, 1'b0);

    // Timeout mid-word: error exactly TIMEOUT idle cycles after the last accepted byte
    do_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    byte_valid_i = 1'b0;
    repeat (Tmo) @(negedge clk_i);
    chk("timeout_not_early", {31'd0, error_o}, 32'd0);
    @(negedge clk_i);
    chk("timeout_error", {31'd0, error_o}, 32'd1);
    chk("timeout_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    chk("timeout_cpu_en", {31'd0, cpu_en_o}, 32'd0);
    chk("timeout_words", {16'd0, words_loaded_o}, 32'd0);
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(1, 1'b0);

    // Asynchronous reset after 1.5 words
    do_start();
    w.addr = Base;
    w.data = 32'h1122_3344;
    exp_q.push_back(w);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    byte_valid_i = 1'b0;
    #3;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs();
    chk("rst_writes_outstanding", 32'(exp_q.size()), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h12, 8'h34, 8'h56, 8'h78};
    run_load(0, 1'b0);

    // Random images: random count (incl. zero/oversize), junk upper header bytes, gaps,
    // stray start pulses and occasional truncation
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(9, 0))
        0:       n = 0;
        1:       n = int'(MaxW) + 1 + int'($urandom_range(3, 0));
        2:       n = 16'hFFFF;
        default: n = int'($urandom_range(MaxW, 1));
      endcase
      nh = 16'(n);
      full = (n == 0 || n > int'(MaxW)) ? 4 : 4 + 4 * n;
      len = full;
      if ($urandom_range(4, 0) == 0) len = int'($urandom_range(full - 1, 0));
      stim.delete();
      stim.push_back(8'($urandom));
      stim.push_back(8'($urandom));
      stim.push_back(nh[15:8]);
      stim.push_back(nh[7:0]);
      for (int i = 4; i < full; i++) stim.push_back(8'($urandom));
      while (stim.size() > len) void'(stim.pop_back());
      run_load(3, 1'b1);
    end

    repeat (3) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Writer side of the instruction memory load port: takes a byte stream of a program image and assembles 32-bit big-endian instruction words.
- Writes each word through the instruction memory write port (address, data, write enable), matching the memory's byte order: byte at address A = data[31:24].
- Holds the processor in reset and disabled until the image is loaded, then releases it.
- Sits between the host/debug byte source and the instruction memory / PC.

Parameters:
BASE_ADDR, 0, byte address of first instruction word written
MAX_WORDS, 1024, largest accepted word count; larger header is an error
TIMEOUT, 1000, cycles without an accepted byte (mid-load) before error

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  pulse; begins a load from IDLE, DONE or ERR
byte_in  input  8  stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader can accept byte this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_addr  output  32  instruction memory write byte address
imem_data  output  32  instruction word, big-endian assembled
cpu_rst  output  1  active-high hold for PC/processor
cpu_en  output  1  processor run enable
busy  output  1  load in progress (HDR, DATA, WRITE)
done  output  1  load completed successfully
error  output  1  load aborted (timeout or oversize)
words_loaded  output  16  count of words written this load

Behaviour:
- Byte transfer occurs on a rising edge when byte_valid && byte_ready. All outputs are registered.
- Reset (rst=0, async):
  - state=IDLE; byte_ready=0, imem_we=0, imem_addr=0, imem_data=0.
  - cpu_rst=1, cpu_en=0, busy=0, done=0, error=0, words_loaded=0.
  - Byte counter and timeout counter cleared.
  - Reset mid-load aborts immediately. Partially written memory is not cleaned.
- States:
  - IDLE: byte_ready=0. start -> HDR.
  - HDR: byte_ready=1. Collects 4 bytes as word count N, big-endian, low 16 bits used.
    - On the 4th accepted byte: N=0 -> DONE; N>MAX_WORDS -> ERR; else -> DATA.
  - DATA: byte_ready=1. Collects 4 bytes into imem_data, first byte -> [31:24]. The 4th accepted byte -> WRITE.
  - WRITE: exactly one cycle.
    - imem_we=1, imem_addr=BASE_ADDR+4*k (k = 0-based word index), byte_ready=0.
    - words_loaded increments at the end of WRITE.
    - Then DATA if words written < N, else DONE.
  - DONE: cpu_rst=0, cpu_en=1, done=1, byte_ready=0.
  - ERR: error=1, cpu_rst=1, cpu_en=0, byte_ready=0.
  - start in DONE or ERR -> HDR. On entering HDR: clear done, error and words_loaded; reassert cpu_rst.
- Output rules:
  - cpu_rst=1 and cpu_en=0 in every state except DONE.
  - imem_we is 0 outside WRITE. imem_addr and imem_data hold their last values.
- Latency: last byte of a word accepted on edge t -> imem_we=1 during cycle t..t+1. byte_ready returns to 1 one cycle later, or done=1 after the final word.
- Throughput: max one word per 5 cycles.
- Backpressure: byte_valid held high during WRITE is not consumed. The same byte is accepted in the next DATA cycle and is never duplicated or dropped.
- Timeout:
  - The counter runs in HDR and DATA, clears on each accepted byte and on state entry.
  - When it reaches TIMEOUT -> ERR. No further imem_we.
- start while busy: ignored.
- Address arithmetic: 32-bit, wraps modulo 2^32.

Test Plan:
1. Normal load (BASE_ADDR=0): start; bytes 00 00 00 02, 20 08 00 05, 01 09 50 20.
   - Expect imem_we pulses at addr 0 data 0x20080005 and addr 4 data 0x01095020.
   - Expect done=1, cpu_en=1, cpu_rst=0, words_loaded=2, error=0.
2. Zero count: header 00 00 00 00.
   - Expect DONE on the next cycle, no imem_we, words_loaded=0, cpu_en=1.
3. Backpressure: byte_valid held high continuously with incrementing bytes 00..0B after header 00 00 00 02.
   - Expect words 0x00010203 and 0x04050607; byte_ready=0 during each WRITE.
   - Expect each byte consumed exactly once; bytes 08..0B not accepted after DONE.
4. Timeout (TIMEOUT=16): header N=1, then 2 data bytes, then byte_valid=0 for 16 cycles.
   - Expect error=1, imem_we never asserted, cpu_rst stays 1.
   - A following start with a valid 1-word image -> done=1.
5. Oversize (MAX_WORDS=4): header 00 00 00 05.
   - Expect ERR right after the 4th header byte, no writes, cpu_en=0.
6. Reset mid-DATA: drive rst=0 asynchronously between clock edges after 1.5 words.
   - Expect all outputs at reset values immediately (cpu_rst=1, busy=0, imem_we=0).
   - After release and start, a full 2-word load succeeds at addr 0 and 4.
